// File: rtl/wb_seg_display_pkg.sv
// Shared definitions for the write-back 7-segment display.
//   SEG_0..SEG_F : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments off
//   dispSel_e    : display source select codes
//   REG_V0/REG_V1: register numbers of $v0 and $v1
package wb_seg_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      DISP_V0  = 2'd0,
      DISP_V1  = 2'd1,
      DISP_MIX = 2'd2,
      DISP_PC  = 2'd3
   } dispSel_e;

   localparam logic [4:0] REG_V0 = 5'd2;
   localparam logic [4:0] REG_V1 = 5'd3;

endpackage

// File: rtl/wb_seg_display_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   nibble : 4-bit value to show
//   seg    : {g,f,e,d,c,b,a}, active-low
module hex_to_seg
   import wb_seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/wb_seg_display.sv
// Write-back observer: shadows $v0/$v1 and drives a multiplexed 8-digit,
// active-low 7-segment display. The shown value is latched once per frame.
//   Clock, Reset         : clock (rising edge), async active-high reset
//   RegWrite, rDestSelected, WriteData : pipeline write-back port
//   ProgramCounter       : display source 3
//   DispSel              : 0=$v0 1=$v1 2={v1[15:0],v0[15:0]} 3=PC
//   Freeze               : hold current frame, scanning continues
//   an, seg, dp          : active-low digit enables / segments / decimal point
//   V0Shadow, V1Shadow   : last values written to $2 / $3
module wb_seg_display
   import wb_seg_display_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_LEADING = 1
)(
   input  logic        Clock,
   input  logic        Reset,
   input  logic        RegWrite,
   input  logic [4:0]  rDestSelected,
   input  logic [31:0] WriteData,
   input  logic [31:0] ProgramCounter,
   input  logic [1:0]  DispSel,
   input  logic        Freeze,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [31:0] V0Shadow,
   output logic [31:0] V1Shadow
);

   localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   logic [DIV_W-1:0] div;
   logic [2:0]       idx;
   logic             scanning;
   logic [31:0]      frame;
   dispSel_e         frameSel;

   logic             tick;
   logic [2:0]       nextIdx;
   logic [31:0]      srcValue;
   logic             latchFrame;
   logic [31:0]      nextFrame;
   dispSel_e         nextFrameSel;
   logic [31:0]      shifted;
   logic             lit;
   logic [6:0]       decoded;
   logic [7:0]       nextAn;
   logic [6:0]       nextSeg;
   logic             nextDp;

   assign tick = (div == DIV_LAST);

   // The first tick after reset lights slot 0 without advancing; from then on
   // idx is the slot currently shown and a frame boundary is the 7->0 wrap.
   always_comb begin
      nextIdx      = scanning ? idx + 3'd1 : 3'd0;
      latchFrame   = tick && scanning && (idx == 3'd7) && !Freeze;
      srcValue     = V0Shadow;
      unique case (dispSel_e'(DispSel))
         DISP_V0:  srcValue = V0Shadow;
         DISP_V1:  srcValue = V1Shadow;
         DISP_MIX: srcValue = {V1Shadow[15:0], V0Shadow[15:0]};
         DISP_PC:  srcValue = ProgramCounter;
      endcase
      nextFrame    = latchFrame ? srcValue : frame;
      nextFrameSel = latchFrame ? dispSel_e'(DispSel) : frameSel;
   end

   // Slot outputs are decoded from the post-edge frame so digit 0 of a new
   // frame already shows the freshly latched value.
   always_comb begin
      shifted = nextFrame >> {nextIdx, 2'b00};
      lit     = (nextIdx == 3'd0) || (BLANK_LEADING == 0) || (shifted != '0);
      nextAn  = lit ? ~(8'b1 << nextIdx) : '1;
      nextSeg = lit ? decoded : SEG_BLANK;
      nextDp  = !(lit && (nextIdx == 3'd4) && (nextFrameSel == DISP_MIX));
   end

   hex_to_seg uDecoder (
      .nibble (shifted[3:0]),
      .seg    (decoded)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         div      <= '0;
         idx      <= '0;
         scanning <= 1'b0;
         frame    <= '0;
         frameSel <= DISP_V0;
         an       <= '1;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
      end else begin
         div <= tick ? '0 : div + 1'b1;
         if (tick) begin
            idx      <= nextIdx;
            scanning <= 1'b1;
            frame    <= nextFrame;
            frameSel <= nextFrameSel;
            an       <= nextAn;
            seg      <= nextSeg;
            dp       <= nextDp;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         V0Shadow <= '0;
         V1Shadow <= '0;
      end else if (RegWrite) begin
         if (rDestSelected == REG_V0) V0Shadow <= WriteData;
         if (rDestSelected == REG_V1) V1Shadow <= WriteData;
      end
   end

endmodule

// File: tb/tb_wb_seg_display.sv
module tb_wb_seg_display;

   localparam int DIV = 4;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        RegWrite = 1'b0;
   logic [4:0]  rDestSelected = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ProgramCounter = 32'h0040_0010;
   logic [1:0]  DispSel = 2'd0;
   logic        Freeze = 1'b0;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [31:0] V0Shadow;
   logic [31:0] V1Shadow;

   int checks = 0;
   int errors = 0;

   wb_seg_display #(.REFRESH_DIV(DIV), .BLANK_LEADING(1)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .RegWrite       (RegWrite),
      .rDestSelected  (rDestSelected),
      .WriteData      (WriteData),
      .ProgramCounter (ProgramCounter),
      .DispSel        (DispSel),
      .Freeze         (Freeze),
      .an             (an),
      .seg            (seg),
      .dp             (dp),
      .V0Shadow       (V0Shadow),
      .V1Shadow       (V1Shadow)
   );

   always #5 Clock = ~Clock;

   // Reference model: counts edges and ticks; the shown digit is (ticks-1)%8.
   logic [6:0]  segTab [16];
   int unsigned mEdges, mTicks;
   logic [31:0] mV0, mV1, mFrame;
   int unsigned mFrameSel;

   initial begin
      segTab[0]  = 7'h40; segTab[1]  = 7'h79; segTab[2]  = 7'h24; segTab[3]  = 7'h30;
      segTab[4]  = 7'h19; segTab[5]  = 7'h12; segTab[6]  = 7'h02; segTab[7]  = 7'h78;
      segTab[8]  = 7'h00; segTab[9]  = 7'h10; segTab[10] = 7'h08; segTab[11] = 7'h03;
      segTab[12] = 7'h46; segTab[13] = 7'h21; segTab[14] = 7'h06; segTab[15] = 7'h0E;
   end

   function automatic logic [31:0] source(input int unsigned sel, input logic [31:0] v0,
                                          input logic [31:0] v1, input logic [31:0] pc);
      case (sel)
         0: return v0;
         1: return v1;
         2: return (v1 << 16) | (v0 & 32'hFFFF);
         default: return pc;
      endcase
   endfunction

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mEdges = 0; mTicks = 0; mV0 = 0; mV1 = 0; mFrame = 0; mFrameSel = 0;
      end else begin
         mEdges++;
         if (mEdges % DIV == 0) begin
            mTicks++;
            if (mTicks > 1 && (mTicks - 1) % 8 == 0 && !Freeze) begin
               mFrame    = source(DispSel, mV0, mV1, ProgramCounter);
               mFrameSel = DispSel;
            end
         end
         if (RegWrite && rDestSelected == 2) mV0 = WriteData;
         if (RegWrite && rDestSelected == 3) mV1 = WriteData;
      end
   end

   function automatic void expected(output logic [7:0] eAn, output logic [6:0] eSeg,
                                    output logic eDp);
      int unsigned d;
      logic [31:0] upper;
      logic lit;
      eAn = 8'hFF; eSeg = 7'h7F; eDp = 1'b1;
      if (mTicks == 0) return;
      d     = (mTicks - 1) % 8;
      upper = mFrame >> (4 * d);
      lit   = (d == 0) || (upper != 0);
      if (lit) begin
         eAn  = 8'hFF - 8'(1 << d);
         eSeg = segTab[upper % 16];
         eDp  = !(d == 4 && mFrameSel == 2);
      end
   endfunction

   // Continuous comparison against the model on every falling edge.
   bit checkEn = 0;
   always @(negedge Clock) begin
      logic [7:0] eAn; logic [6:0] eSeg; logic eDp;
      if (checkEn) begin
         expected(eAn, eSeg, eDp);
         checks++;
         if (an !== eAn || seg !== eSeg || dp !== eDp || V0Shadow !== mV0 || V1Shadow !== mV1) begin
            errors++;
            $display("FAIL model t=%0t an=%h/%h seg=%h/%h dp=%b/%b v0=%h/%h v1=%h/%h",
                     $time, an, eAn, seg, eSeg, dp, eDp, V0Shadow, mV0, V1Shadow, mV1);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge Clock);
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] expV0;
      logic [31:0] expV1;
   } vec_t;

   vec_t vecs [7];
   int dpLow, dpBad, seen5;

   initial begin
      vecs[0] = '{1'b1, 5'd2, 32'h0000_12AB, 32'h0000_12AB, 32'h0};
      vecs[1] = '{1'b1, 5'd0, 32'hDEAD_BEEF, 32'h0000_12AB, 32'h0};
      vecs[2] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_12AB, 32'h0};
      vecs[3] = '{1'b0, 5'd2, 32'hFFFF_FFFF, 32'h0000_12AB, 32'h0};
      vecs[4] = '{1'b1, 5'd3, 32'h0000_0007, 32'h0000_12AB, 32'h7};
      vecs[5] = '{1'b1, 5'd2, 32'h1111_2222, 32'h1111_2222, 32'h7};
      vecs[6] = '{1'b1, 5'd3, 32'h3333_4444, 32'h1111_2222, 32'h3333_4444};

      // Reset state and first tick
      cycles(2);
      check("reset_an", an, 8'hFF);
      check("reset_seg", seg, 7'h7F);
      Reset = 1'b0;
      checkEn = 1;
      cycles(3);
      check("pre_tick_an", an, 8'hFF);
      cycles(1);
      check("first_tick_an", an, 8'hFE);
      check("first_tick_seg", seg, 7'h40);
      check("first_tick_dp", dp, 1'b1);
      cycles(4);
      check("digit1_blank_an", an, 8'hFF);

      // Shadow updates, table-driven
      for (int i = 0; i < 7; i++) begin
         RegWrite = vecs[i].we; rDestSelected = vecs[i].rd; WriteData = vecs[i].data;
         cycles(1);
         RegWrite = 1'b0;
         check($sformatf("shadow_v0_%0d", i), V0Shadow, vecs[i].expV0);
         check($sformatf("shadow_v1_%0d", i), V1Shadow, vecs[i].expV1);
         if (i == 0) cycles(80);  // let 12AB be scanned out
      end

      // Mixed source with decimal point on digit 4
      DispSel = 2'd2;
      dpLow = 0; dpBad = 0;
      for (int c = 0; c < 96; c++) begin
         cycles(1);
         if (dp == 1'b0) begin
            dpLow++;
            if (an != 8'hEF) dpBad++;
         end
      end
      check("dp_only_digit4", dpBad, 0);
      check("dp_seen", dpLow > 0, 1);

      // Freeze holds the frame while $v0 changes
      DispSel = 2'd0;
      cycles(80);
      Freeze = 1'b1;
      RegWrite = 1'b1; rDestSelected = 5'd2; WriteData = 32'h55;
      cycles(1);
      RegWrite = 1'b0;
      seen5 = 0;
      for (int c = 0; c < 72; c++) begin
         cycles(1);
         if (an == 8'hFE && seg == 7'h12) seen5++;
      end
      check("freeze_holds", seen5, 0);
      Freeze = 1'b0;
      for (int c = 0; c < 72; c++) begin
         cycles(1);
         if (an == 8'hFE && seg == 7'h12) seen5++;
      end
      check("unfreeze_shows", seen5 > 0, 1);

      // Randomised traffic
      for (int c = 0; c < 400; c++) begin
         RegWrite       = 1'($urandom_range(0, 1));
         rDestSelected  = 5'($urandom_range(0, 5));
         WriteData      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         ProgramCounter = $urandom;
         if (c % 40 == 0) DispSel = 2'($urandom_range(0, 3));
         if (c % 50 == 0) Freeze  = ($urandom_range(0, 3) == 0);
         cycles(1);
      end
      RegWrite = 1'b0; Freeze = 1'b0;
      cycles(3);

      // Asynchronous reset between edges
      @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("async_an", an, 8'hFF);
      check("async_seg", seg, 7'h7F);
      check("async_dp", dp, 1'b1);
      check("async_v0", V0Shadow, 32'h0);
      check("async_v1", V1Shadow, 32'h0);
      cycles(2);
      Reset = 1'b0;
      cycles(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
